otter_mem_responder: RTL

Memory-side responder for the OTTER core's instruction and data ports. It serves instruction fetches and data loads/stores from an on-chip dual-port RAM. Data accesses at or above `MMIO_BASE` are forwarded to a request/acknowledge I/O bus, and the core is stalled until the I/O bus completes or times out. It sits between `otter_mcu` and the SoC peripherals.

---
 rtl/otter_mem_responder_pkg.sv | 36 +++
 rtl/otter_bram_dp.sv | 54 +++++
 rtl/otter_mem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/otter_mem_responder_pkg.sv
// ============================================================================
// Module      : otter_mem_responder_pkg
// Description : Shared constants for the OTTER memory responder: default MMIO
//               window base, I/O FSM state encodings, timeout read value and
//               byte-lane shift helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package otter_mem_responder_pkg;

  // First byte address routed to the I/O bus
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1100_0000;

  // Value returned to the core when an I/O read times out
  localparam logic [31:0] IO_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // I/O FSM state encodings
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] IO_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] IO_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] IO_DONE = 2'd2;

  // Move right-justified store data into its byte lanes
  function automatic logic [31:0] lane_shl(input logic [31:0] data, input logic [1:0] ofs);
    return data << {ofs, 3'b000};
  endfunction

  // Bring the addressed byte lane of a word down to bit 0
  function automatic logic [31:0] lane_shr(input logic [31:0] data, input logic [1:0] ofs);
    return data >> {ofs, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/otter_bram_dp.sv
// ============================================================================
// Module      : otter_bram_dp
// Description : True dual-port 32-bit RAM. Port A is read-only (instruction
//               fetch); port B has byte-enabled writes with read-before-write.
//               Contents are not reset; only the output registers are.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_bram_dp #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  // Port A: read-only
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [31:0]           a_r_data,
  // Port B: read/write
  input  logic                  b_r_en,
  input  logic [3:0]            b_w_strb,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_w_data,
  output logic [31:0]           b_r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [0:DEPTH-1];

  // Port B byte-lane writes; the array itself carries no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (b_w_strb[i]) begin
        r_mem[b_addr][i*8 +: 8] <= b_w_data[i*8 +: 8];
      end
    end
  end

  // Registered reads; port B only updates on a load so its output holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r_data <= 32'h0;
      b_r_data <= 32'h0;
    end else begin
      a_r_data <= r_mem[a_addr];
      if (b_r_en) begin
        b_r_data <= r_mem[b_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/otter_mem_responder.sv
// ============================================================================
// Module      : otter_mem_responder
// Description : Memory-side responder for the OTTER core. Serves fetches and
//               RAM loads/stores from a dual-port RAM and forwards data
//               accesses at or above MMIO_BASE to a req/ack I/O bus, stalling
//               the core until the bus acknowledges or times out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_mem_responder
  import otter_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction port
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_r_data,
  // Data port
  input  logic        dmem_r_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_w_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        dmem_stall,
  output logic        dmem_err,
  // I/O bus
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_w_data,
  output logic [3:0]  io_w_strb,
  input  logic        io_ack,
  input  logic [31:0] io_r_data
);

  localparam int               CNT_W      = $clog2(IO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_is_mmio;
  logic               w_mmio_req;
  logic               w_ram_rd;
  logic               w_ram_wr;
  logic               w_timeout;
  logic [31:0]        w_st_data;
  logic [31:0]        w_ram_word;
  logic [31:0]        r_io_rdata;
  logic [1:0]         r_ld_ofs;
  logic               r_sel_io;
  logic               r_err;
  logic               w_unused_imem;

  // Only the word-index bits of the fetch address select RAM; the rest wrap
  assign w_unused_imem = ^{imem_addr[31:ADDR_WIDTH+2], imem_addr[1:0]};

  assign w_is_mmio  = (dmem_addr >= MMIO_BASE);
  assign w_mmio_req = (dmem_r_en | dmem_w_en) & w_is_mmio;
  assign w_ram_rd   = dmem_r_en & ~w_is_mmio;
  assign w_ram_wr   = dmem_w_en & ~w_is_mmio;
  assign w_st_data  = lane_shl(dmem_w_data, dmem_addr[1:0]);
  assign w_timeout  = (r_cnt == C_CNT_LAST);

  otter_bram_dp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bram (
    .clk      (clk),
    .rst      (rst),
    .a_addr   (imem_addr[ADDR_WIDTH+1:2]),
    .a_r_data (imem_r_data),
    .b_r_en   (w_ram_rd),
    .b_w_strb (w_ram_wr ? dmem_w_strb : 4'b0000),
    .b_addr   (dmem_addr[ADDR_WIDTH+1:2]),
    .b_w_data (w_st_data),
    .b_r_data (w_ram_word)
  );

  // I/O FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IO_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // I/O FSM next-state: ack takes priority over a coincident timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IO_IDLE: if (w_mmio_req)          w_next_state = IO_REQ;
      IO_REQ:  if (io_ack || w_timeout) w_next_state = IO_DONE;
      IO_DONE:                          w_next_state = IO_IDLE;
      default:                          w_next_state = IO_IDLE;
    endcase
  end

  // I/O FSM outputs: stall from detection until the DONE cycle
  always_comb begin
    io_req     = 1'b0;
    dmem_stall = 1'b0;
    case (r_state)
      IO_IDLE: dmem_stall = w_mmio_req;
      IO_REQ: begin
        io_req     = 1'b1;
        dmem_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // I/O request capture, wait counter, read capture and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_we      <= 1'b0;
      io_addr    <= 32'h0;
      io_w_data  <= 32'h0;
      io_w_strb  <= 4'h0;
      r_cnt      <= '0;
      r_io_rdata <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IO_IDLE && w_mmio_req) begin
        io_we     <= dmem_w_en;
        io_addr   <= dmem_addr;
        io_w_data <= w_st_data;
        io_w_strb <= dmem_w_strb;
      end
      r_cnt <= (r_state == IO_REQ) ? r_cnt + 1'b1 : '0;
      r_err <= (r_state == IO_REQ) && !io_ack && w_timeout;
      // Stores leave the captured read word alone so held load data survives
      if (r_state == IO_REQ && !io_we) begin
        if (io_ack) begin
          r_io_rdata <= io_r_data;
        end else if (w_timeout) begin
          r_io_rdata <= IO_TIMEOUT_DATA;
        end
      end
    end
  end

  // Read-data source select, updated only when a load is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_io <= 1'b0;
      r_ld_ofs <= 2'b00;
    end else if (r_state == IO_DONE && dmem_r_en) begin
      r_sel_io <= 1'b1;
    end else if (w_ram_rd) begin
      r_sel_io <= 1'b0;
      r_ld_ofs <= dmem_addr[1:0];
    end
  end

  assign dmem_r_data = r_sel_io ? r_io_rdata : lane_shr(w_ram_word, r_ld_ofs);
  assign dmem_err    = r_err;

endmodule

`default_nettype wire
